// File: rtl/apb_arb_pkg.sv
// Shared state encoding and width defaults for the APB request arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int SEL_W  = 2;

    // Timeout counter only has to reach TIMEOUT-1; keep at least one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping around.
module apb_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic               any_req_o,
    output logic [PTR_W-1:0]   grant_o
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        any_req_o = |req_i;
        grant_o   = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_i} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_REQ))
                sum = sum - (PTR_W+1)'(NUM_REQ);
            idx = sum[PTR_W-1:0];
            if (!found && req_i[idx]) begin
                found   = 1'b1;
                grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/apb_request_arbiter.sv
// Round-robin arbiter sharing one APB master command port among NUM_REQ requesters.
// One command in flight at a time; a stalled transfer ends with an error response.
module apb_request_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = apb_arb_pkg::DATA_W,
    parameter int ADDR_W  = apb_arb_pkg::ADDR_W,
    parameter int SEL_W   = apb_arb_pkg::SEL_W,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      m_start,
    output logic                      m_write,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_wdata,
    output logic [SEL_W-1:0]          m_sel,
    input  logic                      m_stable,
    input  logic [DATA_W-1:0]         m_rdata
);
    import apb_arb_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    arb_state_t        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  g_q, g_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              any_req;
    logic [PTR_W-1:0]  pick;
    logic [ADDR_W-1:0] addr_a  [NUM_REQ];
    logic [DATA_W-1:0] wdata_a [NUM_REQ];
    logic [SEL_W-1:0]  sel_a   [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
        assign sel_a[i]   = req_sel[i*SEL_W +: SEL_W];
    end

    apb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .any_req_o (any_req),
        .grant_o   (pick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            g_q     <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        g_d       = g_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        sel_d     = sel_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = '0;
        rsp_valid = '0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        m_start   = 1'b0;
        m_write   = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_sel     = '0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    g_d     = pick;
                    write_d = req_write[pick];
                    addr_d  = addr_a[pick];
                    wdata_d = wdata_a[pick];
                    sel_d   = sel_a[pick];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                m_start        = 1'b1;
                m_write        = write_q;
                m_addr         = addr_q;
                m_wdata        = wdata_q;
                m_sel          = sel_q;
                req_ready[g_q] = 1'b1;
                ptr_d          = (g_q == PTR_LAST) ? '0 : g_q + 1'b1;
                cnt_d          = '0;
                state_d        = WAIT;
            end
            WAIT: begin
                m_write = write_q;
                m_addr  = addr_q;
                m_wdata = wdata_q;
                m_sel   = sel_q;
                cnt_d   = cnt_q + 1'b1;
                // Completion wins over a timeout landing in the same cycle.
                if (m_stable) begin
                    rdata_d = write_q ? '0 : m_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid[g_q] = 1'b1;
                rsp_rdata      = rdata_q;
                rsp_err        = err_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_request_arbiter.sv
// Self-checking bench: a behavioural APB slave drives completions, a monitor logs
// issued commands and responses, and each scenario task checks them against a model.
module tb_apb_request_arbiter;

    localparam int N  = 2;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_write = '0;
    logic [N*8-1:0] req_addr = '0;
    logic [N*8-1:0] req_wdata = '0;
    logic [N*2-1:0] req_sel = '0;
    logic [N-1:0]   req_ready, rsp_valid;
    logic [7:0]     rsp_rdata;
    logic           rsp_err;
    logic           m_start, m_write;
    logic [7:0]     m_addr, m_wdata;
    logic [1:0]     m_sel;
    logic           m_stable = 1'b0;
    logic [7:0]     m_rdata = '0;

    apb_request_arbiter #(
        .NUM_REQ (N), .DATA_W (8), .ADDR_W (8), .SEL_W (2), .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .m_start   (m_start),
        .m_write   (m_write),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_sel     (m_sel),
        .m_stable  (m_stable),
        .m_rdata   (m_rdata)
    );

    initial forever #5 clk = ~clk;

    typedef struct { int cyc; int g; logic wr; logic [7:0] addr; logic [7:0] wdata; logic [1:0] sel; } iss_t;
    typedef struct { int cyc; int g; logic [7:0] rdata; logic err; logic [1:0] msel; } rsp_t;

    iss_t       iss_q[$];
    rsp_t       rsp_q[$];
    iss_t       cur;
    int         cyc = 0;
    int         hold_bad = 0;
    bit         in_xfer = 0;
    int         slave_wait = -1;
    logic [7:0] slave_rdata = '0;
    int         mptr = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic int onehot_idx(input logic [N-1:0] v);
        int idx = -1;
        int n = 0;
        for (int i = 0; i < N; i++) if (v[i]) begin idx = i; n++; end
        return (n == 1) ? idx : -1;
    endfunction

    // Reference grant: first valid requester scanning upward from ptr, wrapping.
    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int j = (p + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [32:0] outs();
        return {m_start, m_write, m_addr, m_wdata, m_sel, req_ready, rsp_valid, rsp_rdata, rsp_err};
    endfunction

    // Slave: w cycles after m_start, pulse m_stable for one cycle (w < 0: never).
    initial begin
        int w;
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (m_start && !reset) begin
                w = slave_wait;
                d = slave_rdata;
                if (w > 0) begin
                    repeat (w) @(negedge clk);
                    m_stable = 1'b1;
                    m_rdata  = d;
                    @(negedge clk);
                    m_stable = 1'b0;
                    m_rdata  = 8'($urandom);
                end
            end
        end
    end

    // Monitor: log commands/responses and tally protocol-shape violations.
    initial begin
        iss_t ir;
        rsp_t rr;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                in_xfer = 0;
            end else if (m_start) begin
                if (in_xfer || rsp_valid != '0) hold_bad++;
                ir.cyc = cyc; ir.g = onehot_idx(req_ready); ir.wr = m_write;
                ir.addr = m_addr; ir.wdata = m_wdata; ir.sel = m_sel;
                iss_q.push_back(ir);
                cur = ir;
                in_xfer = 1;
            end else if (rsp_valid != '0) begin
                if (!in_xfer || req_ready != '0 || {m_write, m_addr, m_wdata} != '0) hold_bad++;
                rr.cyc = cyc; rr.g = onehot_idx(rsp_valid); rr.rdata = rsp_rdata;
                rr.err = rsp_err; rr.msel = m_sel;
                rsp_q.push_back(rr);
                in_xfer = 0;
            end else if (in_xfer) begin
                if (req_ready != '0 || m_write !== cur.wr || m_addr !== cur.addr ||
                    m_wdata !== cur.wdata || m_sel !== cur.sel || {rsp_rdata, rsp_err} != '0) hold_bad++;
            end else if (outs() != '0) begin
                hold_bad++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 60 && rsp_q.size() < n; i++) step();
    endtask

    // Raise one requester's command, hold it until req_ready, then drop it.
    task automatic request(input int r, input logic wr, input logic [7:0] a,
                           input logic [7:0] d, input logic [1:0] s);
        req_write[r] = wr;
        req_addr[r*8 +: 8] = a;
        req_wdata[r*8 +: 8] = d;
        req_sel[r*2 +: 2] = s;
        req_valid[r] = 1'b1;
        for (int i = 0; i < 20 && !req_ready[r]; i++) step();
        n_cmp++;
        if (req_ready[r] !== 1'b1) begin
            n_bad++;
            $display("FAIL grant_wait: req_ready[%0d] got %b expected 1 within 20 cycles", r, req_ready[r]);
        end
        req_valid[r] = 1'b0;
        mptr = (r + 1) % N;
    endtask

    task automatic test_reset();
        int br;
        reset = 1'b1;
        slave_wait = -1;
        repeat (3) begin
            step();
            n_cmp++;
            if (outs() !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h expected 0", outs()); end
        end
        reset = 1'b0;
        mptr = 0;
        request(0, 1'b0, 8'h11, 8'h00, 2'd1);
        step();
        step();
        br = rsp_q.size();
        reset = 1'b1;
        repeat (3) begin
            step();
            n_cmp++;
            if (outs() !== '0) begin n_bad++; $display("FAIL reset_mid_wait: got %h expected 0", outs()); end
        end
        reset = 1'b0;
        mptr = 0;
        step();
        step();
        n_cmp++;
        if (rsp_q.size() !== br) begin n_bad++; $display("FAIL reset_no_rsp: got %0d responses expected %0d", rsp_q.size(), br); end
        slave_wait = 3;
        slave_rdata = 8'h3C;
        req_write = '0;
        req_addr = {8'h22, 8'h21};
        req_sel = {2'd2, 2'd1};
        req_valid = 2'b11;
        step();
        n_cmp++;
        if (req_ready !== N'(1 << rr_pick(2'b11, mptr))) begin
            n_bad++; $display("FAIL reset_ptr_grant: got %b expected %b", req_ready, N'(1 << rr_pick(2'b11, mptr)));
        end
        req_valid = '0;
        mptr = (rr_pick(2'b11, mptr) + 1) % N;
        wait_rsp(br + 1);
        n_cmp++;
        if (rsp_q.size() !== br + 1) begin n_bad++; $display("FAIL reset_after_rsp: got %0d expected %0d", rsp_q.size(), br + 1); end
        else if (rsp_q[br].g !== 0 || rsp_q[br].rdata !== 8'h3C) begin
            n_bad++; $display("FAIL reset_after_rsp: got g=%0d rdata=%h expected g=0 rdata=3c", rsp_q[br].g, rsp_q[br].rdata);
        end
    endtask

    task automatic test_write();
        int bi = iss_q.size();
        int br = rsp_q.size();
        slave_wait = 6;
        slave_rdata = 8'hE7;
        request(0, 1'b1, 8'd5, 8'd4, 2'd1);
        wait_rsp(br + 1);
        n_cmp++;
        if (iss_q.size() !== bi + 1 || rsp_q.size() !== br + 1) begin
            n_bad++; $display("FAIL write_count: got %0d/%0d expected %0d/%0d", iss_q.size(), rsp_q.size(), bi + 1, br + 1);
        end else begin
            n_cmp++;
            if ({iss_q[bi].g == 0, iss_q[bi].wr, iss_q[bi].addr, iss_q[bi].wdata, iss_q[bi].sel} !== {1'b1, 1'b1, 8'd5, 8'd4, 2'd1}) begin
                n_bad++; $display("FAIL write_cmd: got g=%0d wr=%b addr=%h wdata=%h sel=%0d expected 0/1/05/04/1",
                                  iss_q[bi].g, iss_q[bi].wr, iss_q[bi].addr, iss_q[bi].wdata, iss_q[bi].sel);
            end
            n_cmp++;
            if (rsp_q[br].g !== 0 || rsp_q[br].err !== 1'b0 || rsp_q[br].rdata !== 8'h00) begin
                n_bad++; $display("FAIL write_rsp: got g=%0d err=%b rdata=%h expected 0/0/00", rsp_q[br].g, rsp_q[br].err, rsp_q[br].rdata);
            end
            n_cmp++;
            if (rsp_q[br].cyc - iss_q[bi].cyc !== 7) begin
                n_bad++; $display("FAIL write_latency: got %0d expected 7", rsp_q[br].cyc - iss_q[bi].cyc);
            end
        end
        n_cmp++;
        if (hold_bad !== 0) begin n_bad++; $display("FAIL write_hold: got %0d violations expected 0", hold_bad); end
    endtask

    task automatic test_read();
        int bi = iss_q.size();
        int br = rsp_q.size();
        int w = $urandom_range(1, 5);
        slave_wait = w;
        slave_rdata = 8'd5;
        request(1, 1'b0, 8'd6, 8'($urandom), 2'd2);
        wait_rsp(br + 1);
        n_cmp++;
        if (rsp_q.size() !== br + 1 || iss_q.size() !== bi + 1) begin
            n_bad++; $display("FAIL read_count: got %0d expected %0d", rsp_q.size(), br + 1);
        end else begin
            n_cmp++;
            if (rsp_q[br].g !== 1 || rsp_q[br].rdata !== 8'd5 || rsp_q[br].err !== 1'b0 || rsp_q[br].msel !== 2'd0) begin
                n_bad++; $display("FAIL read_rsp: got g=%0d rdata=%h err=%b msel=%0d expected 1/05/0/0",
                                  rsp_q[br].g, rsp_q[br].rdata, rsp_q[br].err, rsp_q[br].msel);
            end
            n_cmp++;
            if (rsp_q[br].cyc - iss_q[bi].cyc !== w + 1) begin
                n_bad++; $display("FAIL read_latency: got %0d expected %0d", rsp_q[br].cyc - iss_q[bi].cyc, w + 1);
            end
        end
        n_cmp++;
        if (m_sel !== 2'd0) begin n_bad++; $display("FAIL read_sel_idle: got %0d expected 0", m_sel); end
    endtask

    task automatic test_fairness();
        int bi = iss_q.size();
        int br = rsp_q.size();
        int n = 0;
        int cnt[N] = '{default: 0};
        slave_wait = 2;
        req_write = 2'b10;
        req_addr = {8'h41, 8'h40};
        req_wdata = {8'h91, 8'h90};
        req_sel = {2'd3, 2'd1};
        req_valid = 2'b11;
        for (int i = 0; i < 100 && n < 6; i++) begin
            step();
            if (m_start) begin n++; if (n == 6) req_valid = '0; end
        end
        wait_rsp(br + 6);
        n_cmp++;
        if (iss_q.size() !== bi + 6 || rsp_q.size() !== br + 6) begin
            n_bad++; $display("FAIL fair_count: got %0d/%0d expected 6/6", iss_q.size() - bi, rsp_q.size() - br);
        end else begin
            for (int k = 0; k < 6; k++) begin
                int e = rr_pick(2'b11, mptr);
                mptr = (e + 1) % N;
                if (iss_q[bi+k].g >= 0) cnt[iss_q[bi+k].g]++;
                n_cmp++;
                if (iss_q[bi+k].g !== e || rsp_q[br+k].g !== e || iss_q[bi+k].addr !== 8'h40 + 8'(e)) begin
                    n_bad++; $display("FAIL fair_order[%0d]: got grant=%0d rsp=%0d addr=%h expected %0d", k,
                                      iss_q[bi+k].g, rsp_q[br+k].g, iss_q[bi+k].addr, e);
                end
            end
            n_cmp++;
            if (cnt[0] !== 3 || cnt[1] !== 3) begin
                n_bad++; $display("FAIL fair_ready_cnt: got %0d/%0d expected 3/3", cnt[0], cnt[1]);
            end
        end
    endtask

    task automatic test_timeout();
        int bi = iss_q.size();
        int br = rsp_q.size();
        slave_wait = -1;
        request(0, 1'b0, 8'd7, 8'd0, 2'd2);
        wait_rsp(br + 1);
        n_cmp++;
        if (rsp_q.size() !== br + 1) begin n_bad++; $display("FAIL timeout_count: got %0d expected %0d", rsp_q.size(), br + 1); end
        else begin
            n_cmp++;
            if (rsp_q[br].err !== 1'b1 || rsp_q[br].rdata !== 8'h00 || rsp_q[br].g !== 0) begin
                n_bad++; $display("FAIL timeout_rsp: got err=%b rdata=%h g=%0d expected 1/00/0", rsp_q[br].err, rsp_q[br].rdata, rsp_q[br].g);
            end
            n_cmp++;
            if (rsp_q[br].cyc - iss_q[bi].cyc !== TO + 1) begin
                n_bad++; $display("FAIL timeout_latency: got %0d expected %0d", rsp_q[br].cyc - iss_q[bi].cyc, TO + 1);
            end
        end
        // Completion arriving exactly as the counter reaches TIMEOUT-1.
        bi = iss_q.size();
        br = rsp_q.size();
        slave_wait = TO;
        slave_rdata = 8'hA5;
        request(1, 1'b0, 8'd9, 8'd0, 2'd1);
        wait_rsp(br + 1);
        n_cmp++;
        if (rsp_q.size() !== br + 1) begin n_bad++; $display("FAIL edge_count: got %0d expected %0d", rsp_q.size(), br + 1); end
        else begin
            n_cmp++;
            if (rsp_q[br].err !== 1'b0 || rsp_q[br].rdata !== 8'hA5 || rsp_q[br].g !== 1) begin
                n_bad++; $display("FAIL edge_rsp: got err=%b rdata=%h g=%0d expected 0/a5/1", rsp_q[br].err, rsp_q[br].rdata, rsp_q[br].g);
            end
            n_cmp++;
            if (rsp_q[br].cyc - iss_q[bi].cyc !== TO + 1) begin
                n_bad++; $display("FAIL edge_latency: got %0d expected %0d", rsp_q[br].cyc - iss_q[bi].cyc, TO + 1);
            end
        end
    endtask

    task automatic test_withdraw();
        int bi = iss_q.size();
        int br = rsp_q.size();
        slave_wait = 5;
        slave_rdata = 8'h77;
        request(0, 1'b0, 8'h30, 8'd0, 2'd1);
        step();
        req_addr[15:8] = 8'h31;
        req_sel[3:2] = 2'd2;
        req_valid[1] = 1'b1;
        step();
        step();
        req_valid[1] = 1'b0;
        wait_rsp(br + 1);
        repeat (4) step();
        n_cmp++;
        if (iss_q.size() !== bi + 1 || rsp_q.size() !== br + 1) begin
            n_bad++; $display("FAIL withdraw_count: got %0d/%0d expected 1/1", iss_q.size() - bi, rsp_q.size() - br);
        end else begin
            n_cmp++;
            if (rsp_q[br].g !== 0 || rsp_q[br].rdata !== 8'h77) begin
                n_bad++; $display("FAIL withdraw_rsp: got g=%0d rdata=%h expected 0/77", rsp_q[br].g, rsp_q[br].rdata);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            logic [N-1:0] mask;
            logic         wr_a [N];
            logic [7:0]   ad_a [N];
            logic [7:0]   wd_a [N];
            logic [1:0]   sl_a [N];
            logic [7:0]   d, erd;
            bit           to;
            int           g, w, lat;
            int           bi = iss_q.size();
            int           br = rsp_q.size();
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int r = 0; r < N; r++) begin
                wr_a[r] = 1'($urandom);
                ad_a[r] = 8'($urandom);
                wd_a[r] = 8'($urandom);
                sl_a[r] = 2'($urandom_range(1, 3));
                req_write[r] = wr_a[r];
                req_addr[r*8 +: 8] = ad_a[r];
                req_wdata[r*8 +: 8] = wd_a[r];
                req_sel[r*2 +: 2] = sl_a[r];
            end
            to = ($urandom_range(0, 7) == 0);
            w = to ? -1 : int'($urandom_range(1, TO));
            d = 8'($urandom);
            slave_wait = w;
            slave_rdata = d;
            g = rr_pick(mask, mptr);
            req_valid = mask;
            step();
            n_cmp++;
            if (req_ready !== N'(1 << g)) begin
                n_bad++; $display("FAIL rand_grant[%0d]: got %b expected %b", it, req_ready, N'(1 << g));
            end
            req_valid = '0;
            mptr = (g + 1) % N;
            wait_rsp(br + 1);
            erd = (to || wr_a[g]) ? 8'h00 : d;
            lat = to ? TO + 1 : w + 1;
            n_cmp++;
            if (iss_q.size() !== bi + 1 || rsp_q.size() !== br + 1) begin
                n_bad++; $display("FAIL rand_count[%0d]: got %0d/%0d expected 1/1", it, iss_q.size() - bi, rsp_q.size() - br);
            end else begin
                n_cmp++;
                if ({iss_q[bi].wr, iss_q[bi].addr, iss_q[bi].wdata, iss_q[bi].sel} !== {wr_a[g], ad_a[g], wd_a[g], sl_a[g]}) begin
                    n_bad++; $display("FAIL rand_cmd[%0d]: got %h expected %h", it,
                                      {iss_q[bi].wr, iss_q[bi].addr, iss_q[bi].wdata, iss_q[bi].sel}, {wr_a[g], ad_a[g], wd_a[g], sl_a[g]});
                end
                n_cmp++;
                if (rsp_q[br].g !== g || rsp_q[br].rdata !== erd || rsp_q[br].err !== to) begin
                    n_bad++; $display("FAIL rand_rsp[%0d]: got g=%0d rdata=%h err=%b expected %0d/%h/%b", it,
                                      rsp_q[br].g, rsp_q[br].rdata, rsp_q[br].err, g, erd, to);
                end
                n_cmp++;
                if (rsp_q[br].cyc - iss_q[bi].cyc !== lat) begin
                    n_bad++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, rsp_q[br].cyc - iss_q[bi].cyc, lat);
                end
            end
        end
        n_cmp++;
        if (hold_bad !== 0) begin n_bad++; $display("FAIL protocol_shape: got %0d violations expected 0", hold_bad); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_fairness();
        test_timeout();
        test_withdraw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
